// File: rtl/uriscv_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uriscv_defs (package)
//  Purpose  : Shared encodings and constants for the uriscv fetch stage:
//             sequencer state codes, the NOP substituted on a faulted fetch
//             and the default PC increment.
//  Revision : 1.0 - initial release
// ============================================================================
package uriscv_defs;

    // Fetch sequencer state encodings
    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_REQ  = 2'd1;
    localparam logic [1:0] FETCH_WAIT = 2'd2;
    localparam logic [1:0] FETCH_HOLD = 2'd3;

    // addi x0, x0, 0 - handed to execute in place of a faulted fetch
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Default byte increment between sequential fetches
    localparam int unsigned PC_STEP_DEFAULT = 4;

endpackage : uriscv_defs
`default_nettype wire

// File: rtl/uriscv_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : uriscv_fetch_buffer
//  Purpose  : One-entry holding register for a fetched instruction and its
//             PC. Flush has priority over load; accept empties a full entry.
//             With URISCV_FETCH_BUS_ERROR_EN defined, a fault bit travels
//             with the entry.
//  Revision : 1.0 - initial release
// ============================================================================
module uriscv_fetch_buffer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic        accept_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
`ifdef URISCV_FETCH_BUS_ERROR_EN
    ,
    input  logic        fault_i,
    output logic        fault_o
`endif
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    // Entry occupancy and payload; payload is only rewritten on load so it
    // stays stable while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (accept_i && valid_q) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

`ifdef URISCV_FETCH_BUS_ERROR_EN
    logic fault_q;

    // Fault flag follows the entry and drops as soon as the entry leaves.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_q <= 1'b0;
        end else if (flush_i) begin
            fault_q <= 1'b0;
        end else if (load_i) begin
            fault_q <= fault_i;
        end else if (accept_i && valid_q) begin
            fault_q <= 1'b0;
        end
    end

    assign fault_o = fault_q;
`endif

endmodule : uriscv_fetch_buffer
`default_nettype wire

// File: rtl/uriscv_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : uriscv_fetch
//  Purpose  : Instruction fetch stage. Owns the architectural PC, issues one
//             word read at a time, parks the response in a one-entry buffer
//             for execute, and honours branch redirects by withdrawing or
//             discarding stale fetches.
//  Options  : URISCV_FETCH_BUS_ERROR_EN - adds mem_i_error_i / fetch_fault_o;
//             an errored response is delivered as a NOP flagged as faulted.
//  Revision : 1.0 - initial release
// ============================================================================
module uriscv_fetch
    import uriscv_defs::*;
#(
    parameter logic [31:0] BOOT_VECTOR = 32'h00000000,
    parameter int unsigned PC_STEP     = PC_STEP_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_request_i,
    input  logic [31:0] branch_pc_i,
    output logic        mem_i_rd_o,
    output logic [31:0] mem_i_pc_o,
    input  logic        mem_i_accept_i,
    input  logic        mem_i_valid_i,
    input  logic [31:0] mem_i_inst_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    input  logic        fetch_accept_i
`ifdef URISCV_FETCH_BUS_ERROR_EN
    ,
    input  logic        mem_i_error_i,
    output logic        fetch_fault_o
`endif
);

    localparam logic [31:0] PC_INC = 32'(PC_STEP);

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        discard_q;

    logic        req_accepted;
    logic        wait_no_resp;
    logic        in_flight;
    logic        buf_load;
    logic [31:0] buf_instr;

    // A request is live in memory after this edge if it is being accepted now
    // or we are still waiting and the response has not shown up this cycle.
    assign req_accepted = (state_q == FETCH_REQ) && mem_i_accept_i;
    assign wait_no_resp = (state_q == FETCH_WAIT) && !mem_i_valid_i;
    assign in_flight    = req_accepted || wait_no_resp;

    // Good responses land in the buffer unless stale or overtaken by a redirect.
    assign buf_load = (state_q == FETCH_WAIT) && mem_i_valid_i
                      && !discard_q && !branch_request_i;

`ifdef URISCV_FETCH_BUS_ERROR_EN
    assign buf_instr = mem_i_error_i ? NOP_INSTR : mem_i_inst_i;
`else
    assign buf_instr = mem_i_inst_i;
`endif

    // Sequencer state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect overrides the normal progression.
    // IDLE with discard_q set waits for the orphaned response left by a reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_IDLE: if (!discard_q)      state_d = FETCH_REQ;
            FETCH_REQ:  if (mem_i_accept_i)  state_d = FETCH_WAIT;
            FETCH_WAIT: if (mem_i_valid_i)   state_d = discard_q ? FETCH_IDLE : FETCH_HOLD;
            FETCH_HOLD: if (fetch_accept_i)  state_d = FETCH_REQ;
            default:                         state_d = FETCH_IDLE;
        endcase
        if (branch_request_i) begin
            state_d = in_flight ? FETCH_WAIT : FETCH_IDLE;
        end
    end

    // Memory request outputs are pure functions of the sequencer state
    always_comb begin
        mem_i_rd_o = (state_q == FETCH_REQ);
        mem_i_pc_o = pc_q & ~32'h3;
    end

    // PC, request-PC capture and stale-response tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q      <= BOOT_VECTOR;
            req_pc_q  <= '0;
            // A request already in memory will still answer; mark it stale.
            discard_q <= in_flight;
        end else begin
            if (branch_request_i) begin
                pc_q <= branch_pc_i & ~32'h3;
            end else if (req_accepted) begin
                pc_q <= pc_q + PC_INC;
            end

            if (req_accepted) begin
                req_pc_q <= pc_q;
            end

            if (branch_request_i && in_flight) begin
                discard_q <= 1'b1;
            end else if (mem_i_valid_i
                         && ((state_q == FETCH_WAIT) || (state_q == FETCH_IDLE))) begin
                discard_q <= 1'b0;
            end
        end
    end

    uriscv_fetch_buffer u_buffer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (buf_load),
        .flush_i  (branch_request_i),
        .accept_i (fetch_accept_i),
        .instr_i  (buf_instr),
        .pc_i     (req_pc_q),
        .valid_o  (fetch_valid_o),
        .instr_o  (fetch_instr_o),
        .pc_o     (fetch_pc_o)
`ifdef URISCV_FETCH_BUS_ERROR_EN
        ,
        .fault_i  (mem_i_error_i),
        .fault_o  (fetch_fault_o)
`endif
    );

endmodule : uriscv_fetch
`default_nettype wire

// File: tb/tb_uriscv_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uriscv_fetch
//  Purpose  : Self-checking bench for uriscv_fetch. A memory with fixed
//             latency answers requests; a sequential-stream model tracks the
//             next expected request address and delivered PC; directed
//             scenarios pin reset, stalls, redirects and PC wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uriscv_fetch;

    localparam logic [31:0] BOOT = 32'h80000000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        branch_request_i = 1'b0;
    logic [31:0] branch_pc_i = '0;
    logic        mem_i_rd_o;
    logic [31:0] mem_i_pc_o;
    logic        mem_i_accept_i = 1'b0;
    logic        mem_i_valid_i = 1'b0;
    logic [31:0] mem_i_inst_i = '0;
    logic        fetch_valid_o;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_accept_i = 1'b0;
`ifdef URISCV_FETCH_BUS_ERROR_EN
    logic        mem_i_error_i = 1'b0;
    logic        fetch_fault_o;
`endif

    always #5 clk_i = ~clk_i;

    uriscv_fetch #(
        .BOOT_VECTOR (BOOT),
        .PC_STEP     (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .branch_request_i (branch_request_i),
        .branch_pc_i      (branch_pc_i),
        .mem_i_rd_o       (mem_i_rd_o),
        .mem_i_pc_o       (mem_i_pc_o),
        .mem_i_accept_i   (mem_i_accept_i),
        .mem_i_valid_i    (mem_i_valid_i),
        .mem_i_inst_i     (mem_i_inst_i),
        .fetch_valid_o    (fetch_valid_o),
        .fetch_instr_o    (fetch_instr_o),
        .fetch_pc_o       (fetch_pc_o),
        .fetch_accept_i   (fetch_accept_i)
`ifdef URISCV_FETCH_BUS_ERROR_EN
        ,
        .mem_i_error_i    (mem_i_error_i),
        .fetch_fault_o    (fetch_fault_o)
`endif
    );

    int checks_total  = 0;
    int checks_passed = 0;

    // stimulus controls
    bit          exec_ready = 1'b0;
    bit          mem_ready  = 1'b0;
    int          lat        = 1;
    bit          redir_now  = 1'b0;
    logic [31:0] redir_tgt  = '0;

    // model state
    logic [31:0] exp_pc  = BOOT;
    logic [31:0] exp_req = BOOT;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc = 0;
    bit          prev_redirect = 1'b0;
    bit          prev_rd_stall = 1'b0;
    logic [31:0] prev_rd_addr  = '0;
    logic [31:0] req_log[$];
    logic [31:0] deliv_log[$];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h00000200) return 32'h00A00093;
        return a ^ 32'h3C3C0013;
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
`ifdef URISCV_FETCH_BUS_ERROR_EN
        if (a == 32'h00000040) return 32'h00000013;
`endif
        return memfn(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_log(input string name, input bit deliv, input int idx,
                             input logic [31:0] exp);
        logic [31:0] v;
        int          n;
        n = deliv ? deliv_log.size() : req_log.size();
        if (idx >= n) begin
            checks_total++;
            $display("FAIL %s: got no entry expected %h", name, exp);
        end else begin
            v = deliv ? deliv_log[idx] : req_log[idx];
            check(name, v, exp);
        end
    endtask

    // Observe outputs mid-cycle and compare against the stream model
    task automatic sample();
        @(negedge clk_i);
        if (prev_redirect) check("valid_after_redirect", {31'b0, fetch_valid_o}, 32'd0);
        if (prev_rd_stall) begin
            check("rd_held", {31'b0, mem_i_rd_o}, 32'd1);
            check("rd_addr_held", mem_i_pc_o, prev_rd_addr);
        end
        if (fetch_valid_o) begin
            check("fetch_pc", fetch_pc_o, exp_pc);
            check("fetch_instr", fetch_instr_o, exp_instr(exp_pc));
            check("no_rd_while_buffered", {31'b0, mem_i_rd_o}, 32'd0);
        end
`ifdef URISCV_FETCH_BUS_ERROR_EN
        check("fetch_fault", {31'b0, fetch_fault_o},
              {31'b0, fetch_valid_o && (exp_pc == 32'h00000040)});
`endif
    endtask

    // Drive inputs for the coming edge and advance the model past it
    task automatic drive();
        branch_request_i = redir_now;
        branch_pc_i      = redir_tgt;
        mem_i_accept_i   = mem_ready;
        fetch_accept_i   = exec_ready;
        mem_i_valid_i    = 1'b0;
        mem_i_inst_i     = '0;
`ifdef URISCV_FETCH_BUS_ERROR_EN
        mem_i_error_i    = 1'b0;
`endif
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            mem_i_valid_i = 1'b1;
            mem_i_inst_i  = memfn(pend_addr[0]);
`ifdef URISCV_FETCH_BUS_ERROR_EN
            mem_i_error_i = (pend_addr[0] == 32'h00000040);
`endif
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (mem_i_rd_o && mem_ready) begin
            pend_addr.push_back(mem_i_pc_o);
            pend_due.push_back(cyc + lat);
            if (!redir_now) begin
                check("req_addr", mem_i_pc_o, exp_req);
                req_log.push_back(mem_i_pc_o);
                exp_req = exp_req + 32'd4;
            end
        end
        if (redir_now) begin
            exp_pc  = redir_tgt & ~32'h3;
            exp_req = redir_tgt & ~32'h3;
        end else if (fetch_valid_o && exec_ready) begin
            deliv_log.push_back(fetch_pc_o);
            exp_pc = exp_pc + 32'd4;
        end
        prev_redirect = redir_now;
        prev_rd_stall = mem_i_rd_o && !mem_ready && !redir_now;
        prev_rd_addr  = mem_i_pc_o;
        redir_now     = 1'b0;
        cyc++;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            drive();
        end
    endtask

    function automatic bit cond_met(input int kind);
        case (kind)
            1:       return (pend_addr.size() > 0) && !mem_i_rd_o && !fetch_valid_o;
            2:       return mem_i_rd_o;
            default: return fetch_valid_o;
        endcase
    endfunction

    // Returns right after a sample where the condition holds (inputs not yet driven)
    task automatic wait_cond(input int kind, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            sample();
            if (cond_met(kind)) hit = 1'b1;
            else drive();
        end
        if (!hit) begin
            checks_total++;
            $display("FAIL %s: got timeout expected event", name);
            sample();
        end
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redir_now = 1'b1;
        redir_tgt = tgt;
        drive();
    endtask

    initial begin
        int mr;
        int md;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk_i);
        check("reset_rd", {31'b0, mem_i_rd_o}, 32'd0);
        check("reset_valid", {31'b0, fetch_valid_o}, 32'd0);
        check("reset_instr", fetch_instr_o, 32'd0);
        check("reset_pc", fetch_pc_o, 32'd0);
        rst_i      = 1'b0;
        exec_ready = 1'b1;
        mem_ready  = 1'b1;
        lat        = 1;
        drive();

        // ---------------- sequential boot stream ----------------
        step(12);
        check_log("boot_first_req", 1'b0, 0, 32'h80000000);
        check_log("boot_deliv0", 1'b1, 0, 32'h80000000);
        check_log("boot_deliv1", 1'b1, 1, 32'h80000004);
        check_log("boot_deliv2", 1'b1, 2, 32'h80000008);

        // ---------------- consumer stall holds buffer ----------------
        exec_ready = 1'b0;
        sample();
        redirect(32'h00000200);
        wait_cond(3, "hold_wait_valid");
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'b0, fetch_valid_o}, 32'd1);
            check("hold_instr", fetch_instr_o, 32'h00A00093);
            check("hold_pc", fetch_pc_o, 32'h00000200);
            check("hold_no_rd", {31'b0, mem_i_rd_o}, 32'd0);
            drive();
            sample();
        end
        exec_ready = 1'b1;
        drive();
        step(6);

        // ---------------- redirect while waiting on memory ----------------
        lat = 4;
        wait_cond(1, "wait_state");
        mr = req_log.size();
        md = deliv_log.size();
        redirect(32'h00000100);
        step(24);
        check_log("wait_redir_req", 1'b0, mr, 32'h00000100);
        check_log("wait_redir_deliv", 1'b1, md, 32'h00000100);

        // ---------------- redirect while request unaccepted ----------------
        lat       = 1;
        mem_ready = 1'b0;
        wait_cond(2, "req_state");
        mr = req_log.size();
        redirect(32'h00000102);
        step(2);
        mem_ready = 1'b1;
        step(10);
        check_log("req_redir_req", 1'b0, mr, 32'h00000100);

        // ---------------- PC wrap ----------------
        sample();
        mr = req_log.size();
        md = deliv_log.size();
        redirect(32'hFFFFFFF8);
        step(14);
        check_log("wrap_req0", 1'b0, mr,     32'hFFFFFFF8);
        check_log("wrap_req1", 1'b0, mr + 1, 32'hFFFFFFFC);
        check_log("wrap_req2", 1'b0, mr + 2, 32'h00000000);
        check_log("wrap_deliv2", 1'b1, md + 2, 32'h00000000);

        // ---------------- mixed backpressure ----------------
        lat = 2;
        for (int i = 0; i < 48; i++) begin
            mem_ready  = ((i % 3) != 1);
            exec_ready = ((i % 4) != 2);
            sample();
            if (i == 24) begin
                redir_now = 1'b1;
                redir_tgt = 32'h00000300;
            end
            drive();
        end
        mem_ready  = 1'b1;
        exec_ready = 1'b1;
        step(6);

`ifdef URISCV_FETCH_BUS_ERROR_EN
        // ---------------- bus error delivers faulted NOP ----------------
        exec_ready = 1'b0;
        lat        = 1;
        sample();
        redirect(32'h00000040);
        wait_cond(3, "fault_wait_valid");
        check("fault_flag", {31'b0, fetch_fault_o}, 32'd1);
        check("fault_instr", fetch_instr_o, 32'h00000013);
        check("fault_pc", fetch_pc_o, 32'h00000040);
        exec_ready = 1'b1;
        drive();
        step(8);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_uriscv_fetch
`default_nettype wire

// File: doc/uriscv_fetch.md
Name: uriscv_fetch

Overview:
- Instruction fetch stage. Holds the architectural PC and issues word reads to the instruction memory port.
- Presents fetched instructions to decode/execute through a valid/accept handshake.
- Consumes the branch unit's taken flag and target as a redirect; discards any in-flight stale fetch.
- At most one outstanding memory request, plus a one-entry output buffer.

Parameters:
BOOT_VECTOR, 32'h00000000, PC loaded on reset
PC_STEP, 4, increment applied to the PC after each accepted request

Ports:
clk_i  input  1  clock; all state changes on rising edge
rst_i  input  1  synchronous reset, active-high
branch_request_i  input  1  redirect strobe: taken branch/jump (branch unit output, qualified by execute)
branch_pc_i  input  32  redirect target (branch unit target)
mem_i_rd_o  output  1  instruction read request
mem_i_pc_o  output  32  request address, word aligned
mem_i_accept_i  input  1  memory accepts request this cycle
mem_i_valid_i  input  1  response valid
mem_i_inst_i  input  32  response data
fetch_valid_o  output  1  instruction available to execute
fetch_instr_o  output  32  instruction word
fetch_pc_o  output  32  PC of fetch_instr_o
fetch_accept_i  input  1  execute consumes the instruction this cycle

Behaviour:
- Reset (sync, rst_i=1 at edge):
  - pc_q=BOOT_VECTOR; state=IDLE; discard_q=0; buffer empty.
  - Outputs: mem_i_rd_o=0, fetch_valid_o=0, fetch_instr_o=0, fetch_pc_o=0.
  - Reset mid-request: outstanding response is dropped via discard_q=1 only if a request was pending; otherwise ignored.
- States:
  - IDLE: no request outstanding, buffer empty. Next cycle asserts mem_i_rd_o with mem_i_pc_o=pc_q. Move to REQ.
  - REQ: mem_i_rd_o=1, held stable until mem_i_accept_i. On accept: pc_q+=PC_STEP, and the request PC is latched into req_pc_q. Move to WAIT.
  - WAIT: awaiting mem_i_valid_i. On valid with discard_q=0: capture the instruction and req_pc_q into the buffer and move to HOLD. On valid with discard_q=1: clear discard_q, drop the data, go to IDLE.
  - HOLD: fetch_valid_o=1 from the buffer. On fetch_accept_i: go to REQ immediately (next request issued the same cycle the buffer empties is not required; issue the following cycle).
- Minimum latency: redirect-to-request 1 cycle; request-accept to fetch_valid_o = memory latency + 1.
- Redirect (branch_request_i=1), priority over all else:
  - pc_q<=branch_pc_i with bits [1:0] forced to 0.
  - Buffer invalidated: fetch_valid_o=0 next cycle.
  - REQ not yet accepted: request is withdrawn; state=IDLE.
  - REQ accepted this cycle, or WAIT: discard_q<=1; state=WAIT.
  - Redirect in the same cycle as mem_i_valid_i in WAIT: the response is dropped, discard_q stays 0, state=IDLE.
- Handshake: fetch_instr_o and fetch_pc_o are stable while fetch_valid_o=1 and fetch_accept_i=0. fetch_accept_i while fetch_valid_o=0 is ignored.
- Arithmetic: PC add is 32-bit modulo. 32'hFFFFFFFC+4 wraps to 0, with no flag.
- mem_i_valid_i outside WAIT is ignored (protocol error, not handled).

Optional Feature:
- Macro URISCV_FETCH_BUS_ERROR_EN.
- Defined:
  - Adds input mem_i_error_i (1) and output fetch_fault_o (1).
  - An error response loads the buffer with instr=32'h00000013 (NOP), fetch_fault_o=1. Execute traps.
  - fetch_fault_o is cleared on accept, redirect, or reset.
- Undefined: ports absent; responses are always treated as good.

Decomposition:
- Shared package uriscv_defs: state encodings FETCH_IDLE/REQ/WAIT/HOLD (2 bits), NOP constant 32'h00000013, PC_STEP default.
- One natural sub-module: uriscv_fetch_buffer, a one-entry valid/instr/pc holding register with load, flush and accept.
- Sequencer and PC remain in the top.

Test Plan:
- Reset with BOOT_VECTOR=32'h80000000, memory accept=1 and latency 1 -> first mem_i_pc_o=0x80000000, fetch_pc_o sequence 0x80000000, 0x80000004, 0x80000008.
- fetch_accept_i held 0 for 5 cycles with instr 0x00A00093 buffered -> fetch_valid_o, instr and pc stable; no new mem_i_rd_o.
- Redirect to 0x00000100 while in WAIT -> stale response dropped; next mem_i_pc_o=0x100; fetch_pc_o=0x100 is the first delivered.
- Redirect to 0x00000102 while REQ unaccepted -> request withdrawn; next mem_i_pc_o=0x100.
- pc_q=0xFFFFFFFC -> next request address 0x00000000.
- With URISCV_FETCH_BUS_ERROR_EN: error at 0x40 -> fetch_fault_o=1, fetch_instr_o=0x00000013, fetch_pc_o=0x40.
